alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch
Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have req_valid  input  1  instruction request valid.
REQ-004 SHALL have req_ready  output  1  dispatcher can accept a request; high only in IDLE.
REQ-005 SHALL have req_opcode  input  6  instruction opcode field.
REQ-006 SHALL have req_funct  input  6  R-type funct field.
REQ-007 SHALL have req_shamt  input  5  shift amount field.
REQ-008 SHALL have req_imm  input  16  immediate field.
REQ-009 SHALL have req_rs_val  input  32  rs register value.
REQ-010 SHALL have req_rt_val  input  32  rt register value.
REQ-011 SHALL have alu_op, alu_a, alu_b  output  4/32/32  registered operation code and operands driven to the combinational ALU.
REQ-012 SHALL have alu_out, alu_z, alu_n  input  32/1/1  ALU result, zero flag and negative flag.
REQ-013 SHALL have rsp_valid  output  1  response valid; rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have rsp_result  output  32, rsp_take_branch  output  1 and rsp_illegal  output  1.
Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; IDLE accepts on req_valid&req_ready; EXEC lasts exactly one cycle; RESP holds until rsp_valid&rsp_ready, then IDLE.
REQ-016 On accept, SHALL register decoded alu_op/alu_a/alu_b; they SHALL stay stable until the next accept.
REQ-017 At the EXEC->RESP edge, SHALL capture alu_out, alu_z and alu_n; rsp_valid SHALL rise two edges after the accepting edge.
REQ-018 In RESP, rsp_result/rsp_take_branch/rsp_illegal SHALL remain stable; req_valid SHALL be ignored; no back-to-back response bypass.
REQ-019 R-type (opcode 0x00) decode: funct 0x20/0x21 -> 0000; 0x22/0x23 -> 0001; 0x24 -> 0010; 0x25 -> 0011; 0x26 -> 0100; 0x27 -> 0101; 0x2A -> 0x9 (1001); A=rs, B=rt.
REQ-020 Shifts: funct 0x00 -> 0110, 0x02 -> 0111, 0x03 -> 1000 with A=zero-extended shamt; funct 0x04/0x06/0x07 same codes with A={27'b0,rs[4:0]}; B=rt.
REQ-021 funct 0x08 (jr) -> 1010, A=rs, B=0.
REQ-022 I-type: 0x08/0x09 -> 0000, 0x0A -> 1001 with B=sign-extended imm; 0x0C -> 0010, 0x0D -> 0011, 0x0E -> 0100 with B=zero-extended imm; A=rs.
REQ-023 0x0F (lui) -> 1011, A=0, B={imm,16'b0}.
REQ-024 Branches: 0x04 beq, 0x05 bne -> 0001, A=rs, B=rt; 0x06 blez, 0x07 bgtz -> 1010, A=rs, B=0.
REQ-025 rsp_take_branch: beq=Z, bne=~Z, blez=Z|N, bgtz=~Z&~N; 0 for all non-branches.
REQ-026 Any undecoded opcode/funct SHALL set alu_op=1111, A=B=0, rsp_illegal=1, rsp_result=0, rsp_take_branch=0.
REQ-027 rsp_result SHALL equal the captured alu_out for all legal operations, including branches.
Reset
REQ-028 rst_n low SHALL force IDLE, req_ready=1, rsp_valid=0, and alu_op/alu_a/alu_b, rsp_result, rsp_take_branch, rsp_illegal to 0, regardless of clk.
REQ-029 Reset in EXEC or RESP SHALL abandon the in-flight instruction; no response SHALL be produced after release.
Configuration
REQ-030 Macro ALU_DISPATCH_BRANCH_EN defined: REQ-024/025 branch decode SHALL be active.
REQ-031 Macro undefined: opcodes 0x04-0x07 SHALL be illegal per REQ-026, and rsp_take_branch SHALL be constant 0.
Verification
REQ-032 add (op 0x00, funct 0x20), rs=5, rt=0xFFFFFFF9: alu_op=0000, rsp_valid two edges after accept, rsp_result=0xFFFFFFFE, illegal=0.
REQ-033 sra (funct 0x03), shamt=4, rt=0x80000000: alu_op=1000, alu_a=4, rsp_result=0xF8000000.
REQ-034 With BRANCH_EN: beq rs=rt=0x1234 -> alu_op=0001, take_branch=1; bne with the same operands -> take_branch=0; blez rs=0xFFFFFFFF -> take_branch=1.
REQ-035 rsp_ready held low 5 cycles in RESP, req_valid pulsed: rsp_valid and rsp_result stable, req_ready=0, no second accept; accept occurs the cycle after return to IDLE.
REQ-036 Opcode 0x3F: rsp_illegal=1, rsp_result=0, alu_op=1111; lui imm=0xABCD -> rsp_result=0xABCD0000.
REQ-037 rst_n asserted during EXEC: rsp_valid stays 0, req_ready=1 immediately, all outputs return to 0.

---
 rtl/alu_dispatch.sv | 215 +++++++++++++++++++++
 tb/tb_alu_dispatch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Single-issue ALU dispatcher: decodes one instruction, drives an external combinational ALU
// and holds the response. Define ALU_DISPATCH_BRANCH_EN to enable branch decode (0x04-0x07).
module alu_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_funct,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  input  logic [31:0] req_rs_val,
  input  logic [31:0] req_rt_val,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_take_branch,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_e;
  typedef enum logic [2:0] {BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2,
                            BR_LEZ = 3'd3, BR_GTZ = 3'd4} br_e;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_NOR = 4'b0101,
                         OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SRA = 4'b1000,
                         OP_SLT = 4'b1001, OP_PASSA = 4'b1010, OP_LUI = 4'b1011,
                         OP_ILL = 4'b1111;

  state_e      state_q, state_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic        ill_q, ill_d;
  br_e         br_q, br_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_take_branch_q, rsp_take_branch_d;
  logic        rsp_illegal_q, rsp_illegal_d;

  logic [3:0]  dec_op_s;
  logic [31:0] dec_a_s, dec_b_s;
  logic        dec_ill_s;
  br_e         dec_br_s;
  logic        accept_s, capture_s, take_s;
  logic [31:0] imm_sext_s, imm_zext_s, rs_shamt_s;

  assign imm_sext_s = {{16{req_imm[15]}}, req_imm};
  assign imm_zext_s = {16'h0000, req_imm};
  assign rs_shamt_s = {27'd0, req_rs_val[4:0]};

  // Instruction decode; anything not listed falls through to the illegal defaults.
  always_comb begin
    dec_op_s  = OP_ILL;
    dec_a_s   = 32'h0000_0000;
    dec_b_s   = 32'h0000_0000;
    dec_ill_s = 1'b1;
    dec_br_s  = BR_NONE;
    case (req_opcode)
      6'h00: begin
        dec_ill_s = 1'b0;
        dec_a_s   = req_rs_val;
        dec_b_s   = req_rt_val;
        case (req_funct)
          6'h20, 6'h21: dec_op_s = OP_ADD;
          6'h22, 6'h23: dec_op_s = OP_SUB;
          6'h24:        dec_op_s = OP_AND;
          6'h25:        dec_op_s = OP_OR;
          6'h26:        dec_op_s = OP_XOR;
          6'h27:        dec_op_s = OP_NOR;
          6'h2A:        dec_op_s = OP_SLT;
          6'h00: begin dec_op_s = OP_SLL; dec_a_s = {27'd0, req_shamt}; end
          6'h02: begin dec_op_s = OP_SRL; dec_a_s = {27'd0, req_shamt}; end
          6'h03: begin dec_op_s = OP_SRA; dec_a_s = {27'd0, req_shamt}; end
          6'h04: begin dec_op_s = OP_SLL; dec_a_s = rs_shamt_s; end
          6'h06: begin dec_op_s = OP_SRL; dec_a_s = rs_shamt_s; end
          6'h07: begin dec_op_s = OP_SRA; dec_a_s = rs_shamt_s; end
          6'h08: begin dec_op_s = OP_PASSA; dec_b_s = 32'h0000_0000; end
          default: begin
            dec_ill_s = 1'b1;
            dec_op_s  = OP_ILL;
            dec_a_s   = 32'h0000_0000;
            dec_b_s   = 32'h0000_0000;
          end
        endcase
      end
      6'h08, 6'h09: begin dec_ill_s = 1'b0; dec_op_s = OP_ADD; dec_a_s = req_rs_val; dec_b_s = imm_sext_s; end
      6'h0A: begin dec_ill_s = 1'b0; dec_op_s = OP_SLT; dec_a_s = req_rs_val; dec_b_s = imm_sext_s; end
      6'h0C: begin dec_ill_s = 1'b0; dec_op_s = OP_AND; dec_a_s = req_rs_val; dec_b_s = imm_zext_s; end
      6'h0D: begin dec_ill_s = 1'b0; dec_op_s = OP_OR;  dec_a_s = req_rs_val; dec_b_s = imm_zext_s; end
      6'h0E: begin dec_ill_s = 1'b0; dec_op_s = OP_XOR; dec_a_s = req_rs_val; dec_b_s = imm_zext_s; end
      6'h0F: begin dec_ill_s = 1'b0; dec_op_s = OP_LUI; dec_b_s = {req_imm, 16'h0000}; end
`ifdef ALU_DISPATCH_BRANCH_EN
      6'h04: begin dec_ill_s = 1'b0; dec_op_s = OP_SUB; dec_a_s = req_rs_val; dec_b_s = req_rt_val; dec_br_s = BR_EQ; end
      6'h05: begin dec_ill_s = 1'b0; dec_op_s = OP_SUB; dec_a_s = req_rs_val; dec_b_s = req_rt_val; dec_br_s = BR_NE; end
      6'h06: begin dec_ill_s = 1'b0; dec_op_s = OP_PASSA; dec_a_s = req_rs_val; dec_br_s = BR_LEZ; end
      6'h07: begin dec_ill_s = 1'b0; dec_op_s = OP_PASSA; dec_a_s = req_rs_val; dec_br_s = BR_GTZ; end
`endif
      default: begin
        dec_ill_s = 1'b1;
        dec_op_s  = OP_ILL;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC; else state_d = ST_IDLE;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE; else state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_EXEC: capture_s = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept_s = req_ready & req_valid;

  // Branch outcome from the ALU flags of the instruction in EXEC; non-branches never take.
  always_comb begin
    case (br_q)
      BR_EQ:   take_s = alu_z;
      BR_NE:   take_s = ~alu_z;
      BR_LEZ:  take_s = alu_z | alu_n;
      BR_GTZ:  take_s = ~alu_z & ~alu_n;
      default: take_s = 1'b0;
    endcase
  end

  // Next values for the operand and response registers.
  always_comb begin
    alu_op_d          = alu_op_q;
    alu_a_d           = alu_a_q;
    alu_b_d           = alu_b_q;
    ill_d             = ill_q;
    br_d              = br_q;
    rsp_result_d      = rsp_result_q;
    rsp_take_branch_d = rsp_take_branch_q;
    rsp_illegal_d     = rsp_illegal_q;
    if (accept_s) begin
      alu_op_d = dec_op_s;
      alu_a_d  = dec_a_s;
      alu_b_d  = dec_b_s;
      ill_d    = dec_ill_s;
      br_d     = dec_br_s;
    end else begin
      alu_op_d = alu_op_q;
    end
    if (capture_s) begin
      rsp_result_d      = ill_q ? 32'h0000_0000 : alu_out;
      rsp_take_branch_d = ill_q ? 1'b0 : take_s;
      rsp_illegal_d     = ill_q;
    end else begin
      rsp_result_d = rsp_result_q;
    end
  end

  // Operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q          <= 4'h0;
      alu_a_q           <= 32'h0000_0000;
      alu_b_q           <= 32'h0000_0000;
      ill_q             <= 1'b0;
      br_q              <= BR_NONE;
      rsp_result_q      <= 32'h0000_0000;
      rsp_take_branch_q <= 1'b0;
      rsp_illegal_q     <= 1'b0;
    end else begin
      alu_op_q          <= alu_op_d;
      alu_a_q           <= alu_a_d;
      alu_b_q           <= alu_b_d;
      ill_q             <= ill_d;
      br_q              <= br_d;
      rsp_result_q      <= rsp_result_d;
      rsp_take_branch_q <= rsp_take_branch_d;
      rsp_illegal_q     <= rsp_illegal_d;
    end
  end

  assign alu_op          = alu_op_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_take_branch = rsp_take_branch_q;
  assign rsp_illegal     = rsp_illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural ALU; branch expectations follow
// ALU_DISPATCH_BRANCH_EN.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  req_opcode, req_funct;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [31:0] req_rs_val, req_rt_val;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out, rsp_result;
  logic        alu_z, alu_n, rsp_take_branch, rsp_illegal;

  int checks = 0;
  int failures = 0;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_shamt(req_shamt),
    .req_imm(req_imm), .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_take_branch(rsp_take_branch), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU.
  always_comb begin
    case (alu_op)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = alu_a - alu_b;
      4'b0010: alu_out = alu_a & alu_b;
      4'b0011: alu_out = alu_a | alu_b;
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b0101: alu_out = ~(alu_a | alu_b);
      4'b0110: alu_out = alu_b << alu_a[4:0];
      4'b0111: alu_out = alu_b >> alu_a[4:0];
      4'b1000: alu_out = $signed(alu_b) >>> alu_a[4:0];
      4'b1001: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1010: alu_out = alu_a;
      4'b1011: alu_out = alu_b;
      default: alu_out = 32'h0000_0000;
    endcase
  end
  assign alu_z = (alu_out == 32'h0000_0000);
  assign alu_n = alu_out[31];

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tb;
    logic        ill;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    req_opcode = opc; req_funct = fn; req_shamt = sh;
    req_imm = imm; req_rs_val = rs; req_rt_val = rt;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE, one cycle after the previous edge.
  task automatic run_vec(input int i);
    drive(vecs[i].opc, vecs[i].fn, vecs[i].sh, vecs[i].imm, vecs[i].rs, vecs[i].rt);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk($sformatf("v%0d_op", i), {28'd0, alu_op}, {28'd0, vecs[i].op});
    chk($sformatf("v%0d_a", i), alu_a, vecs[i].a);
    chk($sformatf("v%0d_b", i), alu_b, vecs[i].b);
    chk($sformatf("v%0d_exec_valid", i), {31'd0, rsp_valid}, 32'd0);
    step();
    chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
    chk($sformatf("v%0d_take", i), {31'd0, rsp_take_branch}, {31'd0, vecs[i].tb});
    chk($sformatf("v%0d_ill", i), {31'd0, rsp_illegal}, {31'd0, vecs[i].ill});
    chk($sformatf("v%0d_resp_ready", i), {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_done_valid", i), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_done_ready", i), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 5'd0, 16'h0000, 32'h0000_0005, 32'hFFFF_FFF9, 4'b0000, 32'h0000_0005, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[1]  = '{6'h00, 6'h03, 5'd4, 16'h0000, 32'h1234_5678, 32'h8000_0000, 4'b1000, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0};
    vecs[2]  = '{6'h00, 6'h22, 5'd0, 16'h0000, 32'h0000_000A, 32'h0000_0003, 4'b0001, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0};
    vecs[3]  = '{6'h00, 6'h24, 5'd0, 16'h0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h27, 5'd0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 4'b0101, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[5]  = '{6'h00, 6'h2A, 5'd0, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6]  = '{6'h00, 6'h04, 5'd9, 16'h0000, 32'h0000_0024, 32'h0000_0001, 4'b0110, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0};
    vecs[7]  = '{6'h00, 6'h02, 5'd8, 16'h0000, 32'h0000_0000, 32'h0000_FF00, 4'b0111, 32'h0000_0008, 32'h0000_FF00, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[8]  = '{6'h00, 6'h08, 5'd0, 16'h0000, 32'h0000_0400, 32'h5555_5555, 4'b1010, 32'h0000_0400, 32'h0000_0000, 32'h0000_0400, 1'b0, 1'b0};
    vecs[9]  = '{6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_000F, 1'b0, 1'b0};
    vecs[10] = '{6'h0D, 6'h00, 5'd0, 16'h8000, 32'h0000_0001, 32'h0000_0000, 4'b0011, 32'h0000_0001, 32'h0000_8000, 32'h0000_8001, 1'b0, 1'b0};
    vecs[11] = '{6'h0E, 6'h00, 5'd0, 16'h00FF, 32'h0000_0F0F, 32'h0000_0000, 4'b0100, 32'h0000_0F0F, 32'h0000_00FF, 32'h0000_0FF0, 1'b0, 1'b0};
    vecs[12] = '{6'h0A, 6'h00, 5'd0, 16'hFFFF, 32'hFFFF_FFFE, 32'h0000_0000, 4'b1001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[13] = '{6'h0F, 6'h00, 5'd0, 16'hABCD, 32'h1111_1111, 32'h0000_0000, 4'b1011, 32'h0000_0000, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1'b0};
    vecs[14] = '{6'h3F, 6'h00, 5'd0, 16'h1234, 32'h1111_1111, 32'h2222_2222, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[15] = '{6'h00, 6'h01, 5'd3, 16'h0000, 32'h1111_1111, 32'h2222_2222, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
`ifdef ALU_DISPATCH_BRANCH_EN
    vecs[16] = '{6'h04, 6'h00, 5'd0, 16'h0000, 32'h0000_1234, 32'h0000_1234, 4'b0001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0};
    vecs[17] = '{6'h05, 6'h00, 5'd0, 16'h0000, 32'h0000_1234, 32'h0000_1234, 4'b0001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0};
    vecs[18] = '{6'h06, 6'h00, 5'd0, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1010, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
`else
    vecs[16] = '{6'h04, 6'h00, 5'd0, 16'h0000, 32'h0000_1234, 32'h0000_1234, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[17] = '{6'h05, 6'h00, 5'd0, 16'h0000, 32'h0000_1234, 32'h0000_1234, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[18] = '{6'h06, 6'h00, 5'd0, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
`endif

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    drive(6'h00, 6'h00, 5'd0, 16'h0000, 32'h0, 32'h0);
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Backpressure in RESP with new requests arriving.
    drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'h0000_0001, 32'h0000_0002);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("bp_first_result", rsp_result, 32'h0000_0003);
    drive(6'h0F, 6'h00, 5'd0, 16'h1111, 32'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 1 || c == 2) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("bp%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_result", c), rsp_result, 32'h0000_0003);
      chk($sformatf("bp%0d_ready", c), {31'd0, req_ready}, 32'd0);
      chk($sformatf("bp%0d_op", c), {28'd0, alu_op}, 32'd0);
    end
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_op", {28'd0, alu_op}, 32'd0);
    step();
    req_valid = 1'b0;
    chk("bp_accept_op", {28'd0, alu_op}, 32'hB);
    chk("bp_accept_ready", {31'd0, req_ready}, 32'd0);
    step();
    chk("bp_second_result", rsp_result, 32'h1111_0000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while in EXEC abandons the instruction.
    drive(6'h00, 6'h22, 5'd0, 16'h0000, 32'h0000_0009, 32'h0000_0001);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("rexec_op_before", {28'd0, alu_op}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rexec_ready", {31'd0, req_ready}, 32'd1);
    chk("rexec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rexec_op", {28'd0, alu_op}, 32'd0);
    chk("rexec_a", alu_a, 32'd0);
    chk("rexec_b", alu_b, 32'd0);
    chk("rexec_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("rexec_post%0d_valid", c), {31'd0, rsp_valid}, 32'd0);
    end

    // Reset while in RESP clears the held response.
    drive(6'h0F, 6'h00, 5'd0, 16'hABCD, 32'h0, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("rresp_result_before", rsp_result, 32'hABCD_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rresp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rresp_result", rsp_result, 32'd0);
    chk("rresp_ill", {31'd0, rsp_illegal}, 32'd0);
    chk("rresp_take", {31'd0, rsp_take_branch}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rresp_post_valid", {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
